// File: rtl/i2c_bus_arbiter_pkg.sv
// i2c_bus_arbiter_pkg: state encoding and counter sizing shared by the I2C bus arbiter.
package i2c_bus_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

    function automatic int clog2(input longint unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < v) r++;
        return r;
    endfunction

    // One counter serves both the bus-free gap and the hold watchdog.
    function automatic int cnt_width(input longint unsigned gap, input longint unsigned tmo);
        return clog2((gap > tmo ? gap : tmo) + 1);
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit after last_i with wrap-around.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    // Scanning from the farthest candidate down lets the nearest one win.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_i[(int'(last_i) + k) % N]) begin
                valid_o = 1'b1;
                idx_o   = IW'((int'(last_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin owner of one open-drain I2C bus with a bus-free gap between owners.
// Define I2C_BUS_ARBITER_TIMEOUT_EN to add the hung-owner watchdog.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int COUNT           = 2,
    parameter int CLOCK_FREQUENCY = 200_000_000,
    parameter int GAP_CYCLES      = 1_000,
    parameter int TIMEOUT_CYCLES  = CLOCK_FREQUENCY / 10
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [COUNT-1:0] request_i,
    output logic [COUNT-1:0] grant_o,
    input  logic [COUNT-1:0] client_scl_output_i,
    input  logic [COUNT-1:0] client_sda_output_i,
    output logic [COUNT-1:0] client_scl_input_o,
    output logic [COUNT-1:0] client_sda_input_o,
    output logic             bus_scl_output_o,
    output logic             bus_sda_output_o,
    input  logic             bus_scl_input_i,
    input  logic             bus_sda_input_i,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int IW = COUNT > 1 ? $clog2(COUNT) : 1;
    localparam int CW = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [COUNT-1:0] grant_q, grant_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    last_q, last_d;
    logic             scl_q, scl_d;
    logic             sda_q, sda_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [COUNT-1:0] mask;
    logic             revoke;
    logic             pick_valid;
    logic [IW-1:0]    pick_idx;

    rr_pick #(.N(COUNT), .IW(IW)) u_pick (
        .req_i   (request_i & ~mask),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [COUNT-1:0] mask_q;
    logic             timeout_q;
    assign revoke    = state_q == GRANT && request_i[owner_q] && cnt_q == TMO_LAST;
    assign mask      = mask_q;
    assign timeout_o = timeout_q;
    // A revoked client stays masked until it lets go of request.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mask_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            mask_q    <= (mask_q & request_i) | (revoke ? COUNT'(1) << owner_q : '0);
            timeout_q <= revoke;
        end
    end
`else
    assign revoke    = 1'b0;
    assign mask      = '0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        scl_d   = scl_q;
        sda_d   = sda_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = COUNT'(1) << pick_idx;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                scl_d = client_scl_output_i[owner_q];
                sda_d = client_sda_output_i[owner_q];
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (!request_i[owner_q] || revoke) begin
                    grant_d = '0;
                    scl_d   = 1'b1;
                    sda_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = cnt_q == GAP_LAST ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IW'(COUNT - 1);
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o            = grant_q;
    assign bus_scl_output_o   = scl_q;
    assign bus_sda_output_o   = sda_q;
    assign busy_o             = state_q != IDLE;
    assign client_scl_input_o = {COUNT{bus_scl_input_i}};
    assign client_sda_input_o = {COUNT{bus_sda_input_i}};

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: directed checks of grant order, gap timing, drive muxing, reset and watchdog.
module tb_i2c_bus_arbiter;

    localparam int G = 8;
    localparam int T = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] c_scl = 2'b11;
    logic [1:0] c_sda = 2'b11;
    logic       s_in = 1'b1;
    logic       d_in = 1'b1;
    logic [1:0] grant, scl_in, sda_in;
    logic       scl_out, sda_out, busy, timeout;
    int         checks = 0;
    int         fails = 0;
    int         n;

    i2c_bus_arbiter #(.COUNT(2), .CLOCK_FREQUENCY(500), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
        .clock_i             (clk),
        .reset_i             (rst),
        .request_i           (req),
        .grant_o             (grant),
        .client_scl_output_i (c_scl),
        .client_sda_output_i (c_sda),
        .client_scl_input_o  (scl_in),
        .client_sda_input_o  (sda_in),
        .bus_scl_output_o    (scl_out),
        .bus_sda_output_o    (sda_out),
        .bus_scl_input_i     (s_in),
        .bus_sda_input_i     (d_in),
        .busy_o              (busy),
        .timeout_o           (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        c_scl = 2'b11;
        c_sda = 2'b11;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        // 1: idle after reset
        do_reset();
        tick(100);
        check("idle_grant", grant, 0);
        check("idle_scl", scl_out, 1);
        check("idle_sda", sda_out, 1);
        check("idle_busy", busy, 0);
        check("idle_timeout", timeout, 0);

        // 2: single requester, drive follows owner only
        req = 2'b01;
        tick();
        check("t2_grant", grant, 2'b01);
        check("t2_busy", busy, 1);
        c_sda = 2'b00;
        c_scl = 2'b01;
        tick();
        check("t2_sda_low", sda_out, 0);
        check("t2_scl_owner", scl_out, 1);
        c_sda = 2'b01;
        tick();
        check("t2_sda_high", sda_out, 1);
        d_in = 1'b0;
        s_in = 1'b1;
        #1;
        check("t2_bcast_sda", sda_in, 2'b00);
        check("t2_bcast_scl", scl_in, 2'b11);
        d_in = 1'b1;
        req = 2'b00;
        tick();
        check("t2_rel_grant", grant, 0);
        check("t2_rel_busy", busy, 1);
        tick(G);
        check("t2_gap_end_busy", busy, 0);

        // 3: both request from reset, gap between owners
        do_reset();
        req = 2'b11;
        tick();
        check("t3_first", grant, 2'b01);
        c_sda = 2'b10;
        req = 2'b10;
        tick();
        check("t3_rel", grant, 0);
        for (int i = 0; i < G; i++) begin
            tick();
            check("t3_gap_grant", grant, 0);
            check("t3_gap_sda", sda_out, 1);
        end
        tick();
        check("t3_second", grant, 2'b10);
        c_sda = 2'b11;

        // 4: alternation while both keep requesting
        req = 2'b11;
        for (int r = 0; r < 4; r++) begin
            int o;
            o = (r % 2 == 0) ? 1 : 0;
            req[o] = 1'b0;
            tick();
            check("t4_rel", grant, 0);
            req[o] = 1'b1;
            n = 0;
            while (grant == 2'b00 && n < 40) begin
                tick();
                n++;
            end
            check("t4_grant", grant, 2'b01 << (1 - o));
            check("t4_latency", n, G + 1);
        end

        // 5: hung owner
        do_reset();
        req = 2'b01;
        tick();
        check("t5_grant", grant, 2'b01);
`ifdef I2C_BUS_ARBITER_TIMEOUT_EN
        tick(T - 1);
        check("t5_held", grant, 2'b01);
        check("t5_no_pulse", timeout, 0);
        tick();
        check("t5_revoked", grant, 0);
        check("t5_pulse", timeout, 1);
        tick();
        check("t5_pulse_end", timeout, 0);
        tick(G + 5);
        check("t5_masked", grant, 0);
        req = 2'b00;
        tick();
        req = 2'b01;
        n = 0;
        while (grant == 2'b00 && n < 40) begin
            tick();
            n++;
        end
        check("t5_regrant", grant, 2'b01);
`else
        tick(T + 10);
        check("t5_held", grant, 2'b01);
        check("t5_no_timeout", timeout, 0);
`endif

        // 6: reset mid-transaction
        do_reset();
        req = 2'b01;
        tick();
        c_sda = 2'b10;
        tick();
        check("t6_sda_low", sda_out, 0);
        rst = 1'b1;
        tick();
        check("t6_grant", grant, 0);
        check("t6_sda", sda_out, 1);
        check("t6_busy", busy, 0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
